// File: rtl/pool_pkg.sv
// pool_pkg: shared types and per-channel combine for the 2x2 pooling engine
package pool_pkg;
    typedef enum logic {POOL_MAX, POOL_AVG} pool_mode_t;
    typedef enum logic [1:0] {S_IDLE, S_ROW_EVEN, S_ROW_ODD} pool_state_t;
    localparam int CMB_W = 32;
    function automatic logic [CMB_W-1:0] combine(input logic [CMB_W-1:0] a, input logic [CMB_W-1:0] b, input pool_mode_t m);
        return (m == POOL_AVG) ? a + b : ((a > b) ? a : b);
    endfunction
endpackage

// File: rtl/pool2x2_stream_if.sv
// pool2x2_stream_if: activation input stream and pooled output stream
interface pool2x2_stream_if #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_CH = 4,
    parameter int ADDRESS_WIDTH = 10
);
    logic pool_mode_i;
    logic act_valid_i;
    logic act_last_i;
    logic [NUM_CH*DATA_WIDTH-1:0] act_result_i;
    logic pool_valid_o;
    logic pool_last_o;
    logic [NUM_CH*DATA_WIDTH-1:0] pool_result_o;
    logic [ADDRESS_WIDTH-1:0] pool_result_address_o;
    modport master (
        output pool_mode_i, act_valid_i, act_last_i, act_result_i,
        input pool_valid_o, pool_last_o, pool_result_o, pool_result_address_o
    );
    modport slave (
        input pool_mode_i, act_valid_i, act_last_i, act_result_i,
        output pool_valid_o, pool_last_o, pool_result_o, pool_result_address_o
    );
endinterface

// File: rtl/pool_line_buf.sv
// pool_line_buf: half-row buffer of horizontal pair results, combinational read
module pool_line_buf #(
    parameter int DEPTH = 14,
    parameter int WIDTH = 40,
    parameter int IW = 4
) (
    input  logic clk,
    input  logic we_i,
    input  logic [IW-1:0] idx_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    always_ff @(posedge clk) begin
        if (we_i) mem_q[idx_i] <= wdata_i;
    end
    assign rdata_o = mem_q[idx_i];
endmodule

// File: rtl/pool2x2_stream.sv
// pool2x2_stream: streaming 2x2/stride-2 max/average pooling over raster-order pixels
module pool2x2_stream
    import pool_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_CH = 4,
    parameter int FMAP_W = 28,
    parameter int FMAP_H = 28,
    parameter int ADDRESS_WIDTH = 10
) (
    input logic clk,
    input logic rst,
    pool2x2_stream_if.slave bus
);
    localparam int PW = DATA_WIDTH + 2;
    localparam int HW = FMAP_W / 2;
    localparam int CW = $clog2(FMAP_W);
    localparam int RW = $clog2(FMAP_H);
    localparam int LW = $clog2(HW > 1 ? HW : 2);
    localparam int DW = NUM_CH * DATA_WIDTH;
    pool_state_t state_q, state_d;
    pool_mode_t mode_q, mode_d, cur_mode;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [DW-1:0] h_q, h_d, res_q, res_d, win;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d, addr;
    logic valid_q, valid_d, last_q, last_d;
    logic [NUM_CH*PW-1:0] pair, full, lb_rd;
    logic odd_row, col_end, at_end, lb_we;
    logic [LW-1:0] lb_idx;
    assign cur_mode = (state_q == S_IDLE) ? pool_mode_t'(bus.pool_mode_i) : mode_q;
    assign odd_row = state_q == S_ROW_ODD;
    assign col_end = col_q == CW'(FMAP_W - 1);
    assign at_end = col_end && row_q == RW'(FMAP_H - 1);
    assign lb_idx = LW'(col_q >> 1);
    assign lb_we = bus.act_valid_i && col_q[0] && state_q == S_ROW_EVEN;
    assign addr = ADDRESS_WIDTH'((32'(row_q) >> 1) * HW + (32'(col_q) >> 1));
    for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
        assign pair[c*PW +: PW] = PW'(combine(CMB_W'(h_q[c*DATA_WIDTH +: DATA_WIDTH]),
            CMB_W'(bus.act_result_i[c*DATA_WIDTH +: DATA_WIDTH]), cur_mode));
        assign full[c*PW +: PW] = PW'(combine(CMB_W'(pair[c*PW +: PW]), CMB_W'(lb_rd[c*PW +: PW]), cur_mode));
        // average divides the 4-pixel sum by 4 with truncation
        assign win[c*DATA_WIDTH +: DATA_WIDTH] = (cur_mode == POOL_AVG) ?
            full[c*PW+2 +: DATA_WIDTH] : full[c*PW +: DATA_WIDTH];
    end
    pool_line_buf #(.DEPTH(HW), .WIDTH(NUM_CH*PW), .IW(LW)) u_lb (
        .clk(clk),
        .we_i(lb_we),
        .idx_i(lb_idx),
        .wdata_i(pair),
        .rdata_o(lb_rd)
    );
    always_comb begin
        state_d = state_q;
        mode_d = mode_q;
        col_d = col_q;
        row_d = row_q;
        h_d = h_q;
        valid_d = 1'b0;
        last_d = 1'b0;
        res_d = res_q;
        addr_d = addr_q;
        if (bus.act_valid_i) begin
            mode_d = cur_mode;
            h_d = col_q[0] ? h_q : bus.act_result_i;
            if (odd_row && col_q[0] && (at_end || !bus.act_last_i)) begin
                valid_d = 1'b1;
                res_d = win;
                addr_d = addr;
            end
            if (at_end || bus.act_last_i) begin
                last_d = 1'b1;
                state_d = S_IDLE;
                col_d = '0;
                row_d = '0;
            end else begin
                col_d = col_end ? '0 : col_q + CW'(1);
                row_d = col_end ? row_q + RW'(1) : row_q;
                state_d = row_d[0] ? S_ROW_ODD : S_ROW_EVEN;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            mode_q <= POOL_MAX;
            col_q <= '0;
            row_q <= '0;
            h_q <= '0;
            valid_q <= 1'b0;
            last_q <= 1'b0;
            res_q <= '0;
            addr_q <= '0;
        end else begin
            state_q <= state_d;
            mode_q <= mode_d;
            col_q <= col_d;
            row_q <= row_d;
            h_q <= h_d;
            valid_q <= valid_d;
            last_q <= last_d;
            res_q <= res_d;
            addr_q <= addr_d;
        end
    end
    assign bus.pool_valid_o = valid_q;
    assign bus.pool_last_o = last_q;
    assign bus.pool_result_o = res_q;
    assign bus.pool_result_address_o = addr_q;
endmodule

// File: tb/tb_pool2x2_stream.sv
// tb_pool2x2_stream: per-cycle vector table against a 4x4, 4-channel pooling engine
module tb_pool2x2_stream;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pool2x2_stream_if #(.DATA_WIDTH(8), .NUM_CH(4), .ADDRESS_WIDTH(10)) bus ();
    pool2x2_stream #(.DATA_WIDTH(8), .NUM_CH(4), .FMAP_W(4), .FMAP_H(4), .ADDRESS_WIDTH(10)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic v, l, m;
        logic [31:0] d;
        logic ev, el, ed;
        logic [31:0] er;
        logic [9:0] ea;
    } vec_t;

    vec_t tbl[$];
    int n_vec = 0;
    int n_bad = 0;
    string phase;

    // channel c carries pixel value + 16*c
    function automatic logic [31:0] pk(input int r);
        return {8'(r + 48), 8'(r + 32), 8'(r + 16), 8'(r)};
    endfunction

    task automatic add(input logic v, input logic l, input logic m, input logic [31:0] d,
                       input logic ev, input logic el, input logic ed, input logic [31:0] er, input logic [9:0] ea);
        vec_t r;
        r.v = v; r.l = l; r.m = m; r.d = d;
        r.ev = ev; r.el = el; r.ed = ed; r.er = er; r.ea = ea;
        tbl.push_back(r);
    endtask

    // a full 4x4 frame; m1 is presented from beat 3 on and must be ignored within the frame
    task automatic add_frame(input logic m0, input logic m1, input bit bub, input bit sat,
                             input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2, input logic [31:0] e3);
        logic [31:0] e [4];
        int k;
        bit ob;
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        k = 0;
        for (int i = 0; i < 16; i++) begin
            ob = ((i / 4) % 2 == 1) && (i % 2 == 1);
            if (bub && $urandom_range(0, 2) == 0)
                add(1'b0, 1'($urandom), 1'($urandom), $urandom, 1'b0, 1'b0, 1'b0, 32'd0, 10'd0);
            add(1'b1, i == 15, (i < 3) ? m0 : m1, sat ? 32'hFFFF_FFFF : pk(i),
                ob, i == 15, ob, ob ? e[k] : 32'd0, 10'(k));
            if (ob) k++;
        end
    endtask

    task automatic check(input string nm, input logic ev, input logic el, input logic ed,
                         input logic [31:0] er, input logic [9:0] ea);
        n_vec++;
        if (bus.pool_valid_o !== ev || bus.pool_last_o !== el ||
            (ed && (bus.pool_result_o !== er || bus.pool_result_address_o !== ea))) begin
            n_bad++;
            $display("FAIL %s: got valid=%0b last=%0b res=%h addr=%0d, want valid=%0b last=%0b res=%h addr=%0d",
                     nm, bus.pool_valid_o, bus.pool_last_o, bus.pool_result_o, bus.pool_result_address_o,
                     ev, el, er, ea);
        end
    endtask

    task automatic run_table();
        foreach (tbl[i]) begin
            @(negedge clk);
            bus.act_valid_i = tbl[i].v;
            bus.act_last_i = tbl[i].l;
            bus.pool_mode_i = tbl[i].m;
            bus.act_result_i = tbl[i].d;
            @(posedge clk);
            #1;
            check($sformatf("%s[%0d]", phase, i), tbl[i].ev, tbl[i].el, tbl[i].ed, tbl[i].er, tbl[i].ea);
        end
        tbl.delete();
        @(negedge clk);
        bus.act_valid_i = 1'b0;
        bus.act_last_i = 1'b0;
    endtask

    initial begin
        bus.act_valid_i = 1'b0;
        bus.act_last_i = 1'b0;
        bus.pool_mode_i = 1'b0;
        bus.act_result_i = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset", 1'b0, 1'b0, 1'b1, 32'd0, 10'd0);
        @(negedge clk);
        rst = 1'b1;

        phase = "modes";
        add_frame(1'b0, 1'b0, 1'b0, 1'b0, pk(5), pk(7), pk(13), pk(15));
        add(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, pk(15), 10'd3);
        add_frame(1'b1, 1'b1, 1'b0, 1'b0, pk(2), pk(4), pk(10), pk(12));
        add_frame(1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_table();

        phase = "bubbles_b2b";
        add_frame(1'b0, 1'b0, 1'b1, 1'b0, pk(5), pk(7), pk(13), pk(15));
        add_frame(1'b0, 1'b1, 1'b0, 1'b0, pk(5), pk(7), pk(13), pk(15));
        add_frame(1'b1, 1'b1, 1'b0, 1'b0, pk(2), pk(4), pk(10), pk(12));
        run_table();

        phase = "early_last";
        for (int i = 0; i < 7; i++)
            add(1'b1, i == 6, 1'b0, pk(i), i == 5, i == 6, i == 5, pk(5), 10'd0);
        add_frame(1'b0, 1'b0, 1'b0, 1'b0, pk(5), pk(7), pk(13), pk(15));
        run_table();

        phase = "rst_mid";
        for (int i = 0; i < 7; i++)
            add(1'b1, 1'b0, 1'b0, pk(i), i == 5, 1'b0, i == 5, pk(5), 10'd0);
        run_table();
        @(negedge clk);
        rst = 1'b0;
        bus.act_valid_i = 1'b1;
        bus.act_result_i = pk(7);
        @(posedge clk);
        #1;
        check("rst_mid_hold", 1'b0, 1'b0, 1'b1, 32'd0, 10'd0);
        @(negedge clk);
        rst = 1'b1;
        bus.act_valid_i = 1'b0;
        phase = "after_rst";
        add_frame(1'b1, 1'b1, 1'b0, 1'b0, pk(2), pk(4), pk(10), pk(12));
        run_table();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/pool2x2_stream.md
# pool2x2_stream

Streaming 2x2/stride-2 pooling engine for multi-channel feature maps, placed between the activation unit and the feature-map write-back. Consumes a raster-order pixel stream (row-major, all channels of a pixel in one beat) and emits one pooled pixel per 2x2 window, using a half-row line buffer. Supports max and average modes, selected per frame.

## Interface
- DATA_WIDTH, 8, unsigned bits per channel value
- NUM_CH, 4, channels packed per beat (channel c at bits [c*DATA_WIDTH +: DATA_WIDTH])
- FMAP_W, 28, input map width in pixels; must be even, >= 2
- FMAP_H, 28, input map height in pixels; must be even, >= 2
- ADDRESS_WIDTH, 10, pooled-pixel address width
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset
- pool_mode_i  in  1  0 = max, 1 = average; sampled on first beat of a frame
- act_valid_i  in  1  input beat valid; bubbles allowed, no backpressure
- act_last_i  in  1  final pixel of frame; qualified by act_valid_i
- act_result_i  in  NUM_CH*DATA_WIDTH  channel values
- pool_valid_o  out  1  pooled pixel valid (one-cycle pulse)
- pool_last_o  out  1  end-of-frame pulse
- pool_result_o  out  NUM_CH*DATA_WIDTH  pooled channel values
- pool_result_address_o  out  ADDRESS_WIDTH  pooled pixel index

## Operation
- States: S_IDLE, S_ROW_EVEN, S_ROW_ODD. Counters col (0..FMAP_W-1), row (0..FMAP_H-1), mode register.
- S_IDLE: first valid beat latches pool_mode_i, is processed as (row 0, col 0), moves to S_ROW_EVEN.
- Per accepted beat, per channel: even col loads horizontal register h with the pixel; odd col forms pair = combine(h, pixel).
- combine: max mode = unsigned max; average mode = sum, width DATA_WIDTH+2 (no overflow).
- S_ROW_EVEN, odd col: pair written to line buffer entry col>>1.
- S_ROW_ODD, odd col: result = combine(pair, linebuf[col>>1]); average output = sum>>2 (floor, truncating); max output = max. Registered to outputs with pool_valid_o=1.
- pool_result_address_o = (row>>1)*(FMAP_W/2) + (col>>1), modulo 2^ADDRESS_WIDTH.
- col wraps at FMAP_W-1 to 0, row increments; state toggles EVEN/ODD on wrap.
- Normal end: beat at (FMAP_H-1, FMAP_W-1) with act_last_i=1 → pool_valid_o and pool_last_o asserted together; return to S_IDLE.
- Early last (act_last_i at any other position): no partial window output; pool_last_o pulses with pool_valid_o=0; return to S_IDLE, counters cleared.
- Final pixel without act_last_i: output still produced; pool_last_o pulses with it; return to S_IDLE (frame length is authoritative).
- act_valid_i=0: all state, counters, registers hold.

## Timing
- Latency: pool outputs registered, asserted the cycle after the window's bottom-right beat is accepted; one-cycle pulse.
- Throughput: one input beat per cycle; max one output per 2 input beats on odd rows.
- Reset values: pool_valid_o=0, pool_last_o=0, pool_result_o=0, pool_result_address_o=0; state S_IDLE, counters 0, mode 0. Line buffer not reset (always written before read).
- Reset mid-frame: partial frame discarded, no output pulses; next valid beat is row 0, col 0.
- pool_result_o/address hold last value when pool_valid_o=0.
- Back-to-back frames: beat in the cycle after the last beat is accepted as the new frame's (0,0).

## Structure
- Package pool_pkg: pool_mode_t (POOL_MAX, POOL_AVG), pool_state_t, combine function for one channel.
- Sub-module pool_line_buf: FMAP_W/2 entries x NUM_CH*(DATA_WIDTH+2) bits, 1 write port, combinational read by index.
- Top: FSM, counters, horizontal register, output register stage.

## Test plan
- 4x4, NUM_CH=1, max, pixels 0..15 raster → outputs 5,7,13,15 at addresses 0,1,2,3; pool_last_o with 15.
- Same map, average → 2,4,10,12 (floor(10/4),floor(18/4),…); all channels 255 in average mode → 255 (no overflow).
- NUM_CH=4, channel c = pixel+c*16, max, random bubbles on act_valid_i → results identical to bubble-free run, correct lane packing.
- act_last_i on beat 6 of a 4x4 frame → pool_last_o=1, pool_valid_o=0, one output (none for partial windows after first), next frame starts clean.
- Reset asserted mid-row-1 then new frame → no stale outputs, addresses restart at 0.
- Two back-to-back 4x4 frames, first max, second average (mode changed mid-first-frame is ignored until second frame start).
